// File: rtl/inst_queue_issue.sv
// Fetch packet queue: buffers two-slot IF1 packets and issues them one
// instruction at a time, in program order, to the ID stage.
module inst_queue_issue #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned LOG_DEPTH = 3,
    parameter logic [31:0] INST_NOP  = 32'h0340_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_pc_next,
    input  logic [1:0]  in_pc_taken,
    input  logic [31:0] in_inst0,
    input  logic [31:0] in_inst1,
    input  logic [31:0] in_badv,
    input  logic [6:0]  in_exception,
    input  logic [1:0]  in_excp_flag,
    output logic        space_ok,
    output logic        nearly_full,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc_next,
    output logic        id_taken,
    output logic [31:0] id_badv,
    output logic [6:0]  id_exception,
    output logic        id_excp
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [1:0]  taken;
        logic [31:0] inst0;
        logic [31:0] inst1;
        logic [31:0] badv;
        logic [6:0]  exception;
        logic [1:0]  excp_flag;
    } entry_t;

    localparam logic [LOG_DEPTH:0] CNT_FULL = (LOG_DEPTH+1)'(DEPTH);

    entry_t               mem [DEPTH];
    entry_t               head;
    logic [LOG_DEPTH-1:0] wp;
    logic [LOG_DEPTH-1:0] rp;
    logic [LOG_DEPTH:0]   count;
    logic [LOG_DEPTH:0]   free_cnt;
    logic                 half;
    logic                 head_single;
    logic                 push;
    logic                 issue;
    logic                 pop;

    assign head        = mem[rp];
    // Slot1 is skipped when slot0 redirects, faults, or the packet starts at the upper word
    assign head_single = head.pc[2] | head.taken[0] | head.excp_flag[0];

    assign free_cnt    = CNT_FULL - count;
    assign in_ready    = (count != CNT_FULL);
    assign space_ok    = (free_cnt >= (LOG_DEPTH+1)'(2));
    assign nearly_full = (free_cnt == (LOG_DEPTH+1)'(1));
    assign id_valid    = (count != '0);

    assign push  = in_valid && in_ready;
    assign issue = id_valid && id_ready;
    assign pop   = issue && (half || head_single);

    // Storage needs no reset: pointers and count define what is live
    always_ff @(posedge clk) begin
        if (rstn && !flush && push) begin
            mem[wp] <= '{pc:        in_pc,
                         pc_next:   in_pc_next,
                         taken:     in_pc_taken,
                         inst0:     in_inst0,
                         inst1:     in_inst1,
                         badv:      in_badv,
                         exception: in_exception,
                         excp_flag: in_excp_flag};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            half  <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + LOG_DEPTH'(1);
            end
            if (issue) begin
                if (pop) begin
                    rp   <= rp + LOG_DEPTH'(1);
                    half <= 1'b0;
                end else begin
                    half <= 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   count <= count + (LOG_DEPTH+1)'(1);
                2'b01:   count <= count - (LOG_DEPTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        id_pc        = '0;
        id_inst      = INST_NOP;
        id_pc_next   = '0;
        id_taken     = 1'b0;
        id_badv      = '0;
        id_exception = '0;
        id_excp      = 1'b0;
        if (id_valid) begin
            id_badv      = head.badv;
            id_exception = head.exception;
            if (!half) begin
                id_pc      = head.pc;
                id_inst    = head.inst0;
                id_pc_next = head_single ? head.pc_next : head.pc + 32'd4;
                id_taken   = head.taken[0];
                id_excp    = head.excp_flag[0];
            end else begin
                id_pc      = head.pc + 32'd4;
                id_inst    = head.inst1;
                id_pc_next = head.pc_next;
                id_taken   = head.taken[1];
                id_excp    = head.excp_flag[1];
            end
        end
    end

endmodule

// File: tb/tb_inst_queue_issue.sv
// Self-checking bench for inst_queue_issue: queue-of-packets reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_inst_queue_issue;

    localparam int unsigned DEPTH    = 8;
    localparam logic [31:0] INST_NOP = 32'h0340_0000;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_pc_next;
    logic [1:0]  in_pc_taken;
    logic [31:0] in_inst0;
    logic [31:0] in_inst1;
    logic [31:0] in_badv;
    logic [6:0]  in_exception;
    logic [1:0]  in_excp_flag;
    logic        space_ok;
    logic        nearly_full;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [31:0] id_pc_next;
    logic        id_taken;
    logic [31:0] id_badv;
    logic [6:0]  id_exception;
    logic        id_excp;

    inst_queue_issue #(.DEPTH(8), .LOG_DEPTH(3), .INST_NOP(INST_NOP)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_pc_next(in_pc_next), .in_pc_taken(in_pc_taken),
        .in_inst0(in_inst0), .in_inst1(in_inst1), .in_badv(in_badv),
        .in_exception(in_exception), .in_excp_flag(in_excp_flag),
        .space_ok(space_ok), .nearly_full(nearly_full),
        .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc),
        .id_inst(id_inst), .id_pc_next(id_pc_next), .id_taken(id_taken),
        .id_badv(id_badv), .id_exception(id_exception), .id_excp(id_excp)
    );

    typedef struct {
        logic [31:0] pc, pc_next, inst0, inst1, badv;
        logic [1:0]  taken, excp;
        logic [6:0]  exc;
    } pkt_t;

    pkt_t mq[$];
    bit   mhalf;
    bit   model_ok;
    int   n_checks;
    int   n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a packet stays at the head until each of its live slots has issued
    function automatic int slots(input pkt_t p);
        return (p.pc[2] || p.taken[0] || p.excp[0]) ? 1 : 2;
    endfunction

    task automatic model_update();
        pkt_t p;
        bit do_issue, do_push;
        if (!rstn || flush) begin
            mq.delete();
            mhalf    = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            do_issue = (mq.size() != 0) && id_ready;
            do_push  = (mq.size() != DEPTH) && in_valid;
            if (do_issue) begin
                if (!mhalf && slots(mq[0]) == 2) mhalf = 1'b1;
                else begin
                    void'(mq.pop_front());
                    mhalf = 1'b0;
                end
            end
            if (do_push) begin
                p.pc = in_pc; p.pc_next = in_pc_next; p.inst0 = in_inst0;
                p.inst1 = in_inst1; p.badv = in_badv; p.taken = in_pc_taken;
                p.excp = in_excp_flag; p.exc = in_exception;
                mq.push_back(p);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Per-cycle comparison against the model
    initial begin
        pkt_t h;
        int   free;
        forever begin
            @(negedge clk);
            if (model_ok) begin
                free = DEPTH - mq.size();
                chk("in_ready", in_ready, free != 0);
                chk("space_ok", space_ok, free >= 2);
                chk("nearly_full", nearly_full, free == 1);
                chk("id_valid", id_valid, mq.size() != 0);
                if (mq.size() == 0) begin
                    chk("id_pc", id_pc, 0);
                    chk("id_inst", id_inst, INST_NOP);
                    chk("id_pc_next", id_pc_next, 0);
                    chk("id_taken", id_taken, 0);
                    chk("id_badv", id_badv, 0);
                    chk("id_exception", id_exception, 0);
                    chk("id_excp", id_excp, 0);
                end else begin
                    h = mq[0];
                    chk("id_badv", id_badv, h.badv);
                    chk("id_exception", id_exception, 32'(h.exc));
                    if (!mhalf) begin
                        chk("id_pc", id_pc, h.pc);
                        chk("id_inst", id_inst, h.inst0);
                        chk("id_pc_next", id_pc_next, slots(h) == 1 ? h.pc_next : h.pc + 32'd4);
                        chk("id_taken", id_taken, 32'(h.taken[0]));
                        chk("id_excp", id_excp, 32'(h.excp[0]));
                    end else begin
                        chk("id_pc", id_pc, h.pc + 32'd4);
                        chk("id_inst", id_inst, h.inst1);
                        chk("id_pc_next", id_pc_next, h.pc_next);
                        chk("id_taken", id_taken, 32'(h.taken[1]));
                        chk("id_excp", id_excp, 32'(h.excp[1]));
                    end
                end
            end
        end
    end

    task automatic set_pkt(input logic [31:0] pc, input logic [31:0] pcn,
                           input logic [1:0] tk, input logic [1:0] ex,
                           input logic [6:0] exc, input logic [31:0] badv);
        in_pc = pc; in_pc_next = pcn; in_pc_taken = tk; in_excp_flag = ex;
        in_exception = exc; in_badv = badv;
        in_inst0 = pc ^ 32'hA5A5_0000; in_inst1 = pc ^ 32'h5A5A_0000;
        in_valid = 1'b1;
    endtask

    initial begin
        logic [31:0] base;
        n_checks = 0; n_fail = 0; model_ok = 1'b0; mhalf = 1'b0;
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; id_ready = 1'b0;
        set_pkt(0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        cycle(); cycle();
        rstn = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_space_ok", space_ok, 1);
        chk("rst_nearly_full", nearly_full, 0);
        chk("rst_id_inst", id_inst, INST_NOP);

        // Two-slot packet issues as two consecutive instructions
        id_ready = 1'b1;
        set_pkt(32'h1c00_0000, 32'h1c00_0008, 2'b00, 2'b00, 0, 0);
        cycle(); in_valid = 1'b0;
        chk("t1_pc0", id_pc, 32'h1c00_0000);
        chk("t1_pcn0", id_pc_next, 32'h1c00_0004);
        cycle();
        chk("t1_pc1", id_pc, 32'h1c00_0004);
        chk("t1_pcn1", id_pc_next, 32'h1c00_0008);
        cycle();
        chk("t1_empty", id_valid, 0);
        chk("t1_nop", id_inst, INST_NOP);

        // Upper-word start: single issue
        set_pkt(32'h1c00_000c, 32'h1c00_0010, 2'b00, 2'b00, 0, 0);
        cycle(); in_valid = 1'b0;
        chk("t2_pc", id_pc, 32'h1c00_000c);
        chk("t2_inst", id_inst, 32'h1c00_000c ^ 32'hA5A5_0000);
        chk("t2_pcn", id_pc_next, 32'h1c00_0010);
        cycle();
        chk("t2_empty", id_valid, 0);

        // Slot0 taken: single issue with its target
        set_pkt(32'h1c00_0010, 32'h1c00_0100, 2'b01, 2'b00, 0, 0);
        cycle(); in_valid = 1'b0;
        chk("t2b_taken", id_taken, 1);
        chk("t2b_pcn", id_pc_next, 32'h1c00_0100);
        cycle();
        chk("t2b_empty", id_valid, 0);

        // Slot0 fault: single issue carrying the exception
        set_pkt(32'h1c00_0000, 32'h1c00_0008, 2'b00, 2'b01, 7'h08, 32'h1c00_0000);
        cycle(); in_valid = 1'b0;
        chk("t3_excp", id_excp, 1);
        chk("t3_exc", id_exception, 32'h08);
        chk("t3_badv", id_badv, 32'h1c00_0000);
        cycle();
        chk("t3_empty", id_valid, 0);

        // Fill to full with ID stalled, then drain across the pointer wrap
        id_ready = 1'b0;
        base = 32'h1c00_1000;
        for (int i = 0; i < 8; i++) begin
            set_pkt(base + 32'(8 * i), base + 32'(8 * i + 8), 0, 0, 0, 0);
            cycle();
            if (i + 1 == 6) chk("t4_space6", space_ok, 1);
            if (i + 1 == 7) begin
                chk("t4_space7", space_ok, 0);
                chk("t4_nf7", nearly_full, 1);
                chk("t4_rdy7", in_ready, 1);
            end
            if (i + 1 == 8) begin
                chk("t4_rdy8", in_ready, 0);
                chk("t4_nf8", nearly_full, 0);
            end
        end
        set_pkt(32'hdead_0000, 32'hdead_0008, 0, 0, 0, 0);
        cycle();
        chk("t4_full_hold", in_ready, 0);
        in_valid = 1'b0; id_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("t4_order", id_pc, base + 32'(8 * (k / 2) + 4 * (k % 2)));
            cycle();
        end
        chk("t4_drained", id_valid, 0);

        // Flush mid-packet with a concurrent push
        id_ready = 1'b0;
        base = 32'h1c00_2000;
        for (int i = 0; i < 5; i++) begin
            set_pkt(base + 32'(8 * i), base + 32'(8 * i + 8), 0, 0, 0, 0);
            cycle();
        end
        in_valid = 1'b0; id_ready = 1'b1;
        cycle();
        chk("t5_half", id_pc, base + 32'd4);
        flush = 1'b1;
        set_pkt(32'h1c00_3000, 32'h1c00_3008, 0, 0, 0, 0);
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_flush_valid", id_valid, 0);
        chk("t5_flush_rdy", in_ready, 1);
        id_ready = 1'b0;
        set_pkt(32'h1c00_4000, 32'h1c00_4008, 0, 0, 0, 0);
        cycle(); in_valid = 1'b0;
        chk("t5_slot0", id_pc, 32'h1c00_4000);
        chk("t5_inst0", id_inst, 32'h1c00_4000 ^ 32'hA5A5_0000);

        // Reset mid-stream drops the in-flight push
        id_ready = 1'b1;
        cycle();
        set_pkt(32'h1c00_5000, 32'h1c00_5008, 0, 0, 0, 0);
        cycle();
        rstn = 1'b0;
        set_pkt(32'h1c00_6000, 32'h1c00_6008, 0, 0, 0, 0);
        cycle();
        rstn = 1'b1; in_valid = 1'b0;
        chk("t6_valid", id_valid, 0);
        chk("t6_pc", id_pc, 0);
        chk("t6_nop", id_inst, INST_NOP);
        chk("t6_space", space_ok, 1);
        cycle();
        chk("t6_lost", id_valid, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            set_pkt($urandom & 32'hffff_fffc, $urandom & 32'hffff_fffc,
                    ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom),
                    ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                    7'($urandom), $urandom);
            in_inst0 = $urandom; in_inst1 = $urandom;
            in_valid = ($urandom_range(0, 9) < 7);
            id_ready = ($urandom_range(0, 9) < 6);
            flush    = ($urandom_range(0, 99) < 2);
            rstn     = ($urandom_range(0, 99) != 0);
            cycle();
        end
        rstn = 1'b1; flush = 1'b0; in_valid = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_queue_issue.md
# inst_queue_issue

Read side of the fetch packet path. Accepts two-slot fetch packets from the IF1 stage register over a valid/ready handshake and buffers them in a circular queue. Splits each packet into single instructions and presents them in program order to the ID stage. Generates the `space_ok` / `nearly_full` occupancy hints that the IF1 stage uses to throttle icache requests.

## Interface
- `DEPTH`, 8: packet entries in the queue; must be a power of two, at least 4.
- `LOG_DEPTH`, 3: log2(`DEPTH`).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  synchronous reset, active-low.
- `flush`  in  1  discard all queued and in-flight packets.
- `in_valid`  in  1  IF1 packet valid; this is IF1's `fifo_readygo`.
- `in_ready`  out  1  queue can accept; drives IF1's `fifo_allowin`.
- `in_pc`  in  32  packet PC; slot0 address.
- `in_pc_next`  in  32  predicted fetch target after the packet's last valid slot.
- `in_pc_taken`  in  2  per-slot predicted-taken.
- `in_inst0`, `in_inst1`  in  32 each  slot instructions.
- `in_badv`  in  32  fetch fault address.
- `in_exception`  in  7  fetch exception code.
- `in_excp_flag`  in  2  per-slot exception present.
- `space_ok`  out  1  free entries ≥ 2.
- `nearly_full`  out  1  free entries == 1.
- `id_ready`  in  1  ID accepts the instruction.
- `id_valid`  out  1  instruction presented.
- `id_pc`  out  32  instruction PC.
- `id_inst`  out  32  instruction word.
- `id_pc_next`  out  32  predicted next PC for this instruction.
- `id_taken`  out  1  predicted taken.
- `id_badv`  out  32  fault address.
- `id_exception`  out  7  exception code.
- `id_excp`  out  1  this instruction carries a fetch exception.

## Operation
- Storage: `DEPTH` entries of {pc, pc_next, taken[1:0], inst0, inst1, badv, exception, excp_flag[1:0]}. Write pointer `wp`, read pointer `rp`, each `LOG_DEPTH` bits and wrapping modulo `DEPTH`. `count` is `LOG_DEPTH+1` bits wide.
- Push happens when `in_valid && in_ready`.
  - `in_ready` = `count != DEPTH`. A pop in the same cycle does not raise `in_ready`; there is no bypass.
- Slot count `n` per entry:
  - `n` = 1 if `pc[2]` or `taken[0]` or `excp_flag[0]`.
  - Otherwise `n` = 2.
- Slot selector register `half`:
  - 0 selects slot0; 1 selects slot1.
  - It is only ever 1 when the head entry has `n` == 2.
- Head, slot0:
  - `id_pc` = pc; `id_inst` = inst0; `id_taken` = taken[0]; `id_excp` = excp_flag[0].
  - `id_pc_next` = (`n` == 1) ? pc_next : pc+4 (32-bit wrap).
- Head, slot1:
  - `id_pc` = pc+4; `id_inst` = inst1; `id_pc_next` = pc_next; `id_taken` = taken[1]; `id_excp` = excp_flag[1].
- `id_badv` and `id_exception` pass through from the entry for both slots.
- Issue happens when `id_valid && id_ready`:
  - If `half` == 0 and `n` == 2: set `half` = 1 and do not pop.
  - Otherwise: pop (`rp`+1), set `half` = 0.
- `id_valid` = `count != 0`.
  - While `id_valid` = 0, all `id_*` data outputs are 0, except `id_inst` = `INST_NOP`.
- Occupancy hints:
  - `space_ok` = (`DEPTH` − `count`) ≥ 2.
  - `nearly_full` = (`DEPTH` − `count`) == 1.
- Simultaneous push and pop: `count` is unchanged; both pointers advance.

## Timing
- Reset (`rstn` = 0 at an edge):
  - Clears `wp`, `rp`, `count`, `half`; storage contents are don't-care.
  - Outputs after that edge: `in_ready` = 1, `space_ok` = 1, `nearly_full` = 0, `id_valid` = 0, `id_inst` = `INST_NOP`, all other `id_*` = 0.
  - Reset asserted mid-packet (`half` = 1) fully abandons that packet.
- Latency: a packet pushed at edge t is presented on `id_*` in the cycle after edge t. There is no combinational path from `in_*` to `id_*`.
- `id_*` outputs are combinational from the head entry and `half`. Their values are held stable while `id_valid && !id_ready`.
- `in_ready`, `space_ok` and `nearly_full` depend only on registered `count`. There is no combinational path from `id_ready`.
- `flush` = 1 at an edge:
  - Same effect as reset on pointers, `count` and `half`.
  - A concurrent push is dropped and a concurrent issue is not counted.
  - `flush` has priority over everything except `rstn`.
- Full (`count` == `DEPTH`): `in_ready` = 0. IF1 holds its register.
- Wrap-around: `wp` and `rp` roll over `DEPTH`−1 → 0 with no bubble.

## Test plan
- Reset then single push (pc = 0x1c000000, pc[2] = 0, taken = 0, excp_flag = 0, pc_next = 0x1c000008), `id_ready` = 1 → two issues on consecutive cycles:
  - first: pc 0x1c000000, `id_pc_next` 0x1c000004;
  - second: pc 0x1c000004, `id_pc_next` 0x1c000008;
  - then `id_valid` = 0, `id_inst` = `INST_NOP`.
- Push pc = 0x1c00000c → exactly one issue: inst0, pc 0x1c00000c, `id_pc_next` = `in_pc_next`. Push taken = 2'b01 → one issue, `id_taken` = 1.
- Push excp_flag = 2'b01, exception = 7'h08, badv = 0x1c000000 → one issue with `id_excp` = 1, `id_exception` = 0x08, `id_badv` = 0x1c000000; slot1 never presented.
- `id_ready` = 0, push 8 two-slot packets:
  - `space_ok` falls when `count` = 7; `nearly_full` = 1 at `count` = 7; `in_ready` = 0 at `count` = 8;
  - release `id_ready` → 16 issues in order with pointers wrapping.
- `flush` while `half` = 1 with 5 entries and a concurrent push → next cycle `id_valid` = 0, `count` = 0, `half` = 0. The next push issues slot0 first.
- `rstn` = 0 for one edge mid-stream with `in_valid` = 1 → all outputs at reset values next cycle and the pushed packet is lost.
